// File: rtl/bell_pkg_57.sv
// Shared types and constants for the bell/LED sound scheduler.
package bell_pkg_57;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        CHIME = 2'd2
    } state_t;

    localparam logic [3:0] CHIME_MAX     = 4'd12;
    localparam logic [4:0] HOUR_NOON_BIN = 5'd12;
    localparam int         TICK_W        = $clog2(1024);

endpackage

// File: rtl/bell_sched_57_bcd.sv
// Maps a BCD hour (00..23) to the number of chime beeps on a 12-hour dial.
module bcd_hour_to_chime_57
    import bell_pkg_57::*;
(
    input  logic [6:0] i_hour_bcd,
    output logic [3:0] o_beeps
);

    logic [6:0] w_bin;
    logic [6:0] w_noon;

    assign w_bin  = 7'(i_hour_bcd[6:4]) * 7'd10 + 7'(i_hour_bcd[3:0]);
    assign w_noon = 7'(HOUR_NOON_BIN);

    // Afternoon hours wrap by 12; the low nibble alone is enough for bin-12.
    always_comb begin
        o_beeps = w_bin[3:0];
        if (w_bin == 7'd0 || w_bin == w_noon) begin
            o_beeps = CHIME_MAX;
        end else if (w_bin > w_noon) begin
            o_beeps = w_bin[3:0] - w_noon[3:0];
        end
    end

endmodule

// File: rtl/bell_sched_57.sv
// Arbitrates alarm and hourly-chime requests and sequences buzzer/LED patterns on a 2 Hz tick.
module bell_sched_57
    import bell_pkg_57::*;
#(
    parameter int ALARM_TICKS = 120
) (
    input  logic       clk_50m_57,
    input  logic       rst_n_57,
    input  logic       tick_2hz_57,
    input  logic       alarm_req_57,
    input  logic       chime_req_57,
    input  logic [6:0] hour_bcd_57,
    input  logic       stop_57,
    output logic       buzzer_57,
    output logic       led_57,
    output logic       busy_57,
    output logic       sound_model_57
);

    localparam logic [TICK_W-1:0] ALARM_LIMIT = TICK_W'(ALARM_TICKS);

    state_t            r_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_buzzer;
    logic              r_led;
    logic              r_sound_model;
    logic              r_chime_pend;
    logic [3:0]        r_pend_n;
    logic [3:0]        r_beep_cnt;
    logic              r_phase_on;

    state_t            w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [TICK_W-1:0] w_tick_inc;
    logic              w_buzzer_nxt;
    logic              w_led_nxt;
    logic              w_sound_model_nxt;
    logic              w_pend_nxt;
    logic [3:0]        w_pend_n_nxt;
    logic [3:0]        w_beep_nxt;
    logic              w_phase_on_nxt;
    logic [3:0]        w_chime_n;

    bcd_hour_to_chime_57 u_bcd (
        .i_hour_bcd (hour_bcd_57),
        .o_beeps    (w_chime_n)
    );

    assign w_tick_inc = r_tick_cnt + TICK_W'(1);

    // Priority: alarm request, then stop, then tick; a tick arriving with a request is dropped.
    always_comb begin
        w_state_nxt       = r_state;
        w_tick_nxt        = r_tick_cnt;
        w_buzzer_nxt      = r_buzzer;
        w_led_nxt         = r_led;
        w_sound_model_nxt = r_sound_model;
        w_pend_nxt        = r_chime_pend;
        w_pend_n_nxt      = r_pend_n;
        w_beep_nxt        = r_beep_cnt;
        w_phase_on_nxt    = r_phase_on;

        if (alarm_req_57) begin
            w_state_nxt       = ALARM;
            w_tick_nxt        = '0;
            w_buzzer_nxt      = 1'b1;
            w_led_nxt         = 1'b1;
            w_sound_model_nxt = 1'b0;
            if (chime_req_57) begin
                w_pend_nxt   = 1'b1;
                w_pend_n_nxt = w_chime_n;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (chime_req_57 || (r_chime_pend && !stop_57)) begin
                        w_state_nxt       = CHIME;
                        w_buzzer_nxt      = 1'b1;
                        w_led_nxt         = 1'b1;
                        w_sound_model_nxt = 1'b1;
                        w_phase_on_nxt    = 1'b1;
                        w_beep_nxt        = chime_req_57 ? w_chime_n : r_pend_n;
                        if (!chime_req_57) begin
                            w_pend_nxt = 1'b0;
                        end
                    end else if (stop_57) begin
                        w_pend_nxt = 1'b0;
                    end
                end
                ALARM: begin
                    if (stop_57) begin
                        w_state_nxt  = IDLE;
                        w_buzzer_nxt = 1'b0;
                        w_led_nxt    = 1'b0;
                        w_pend_nxt   = 1'b0;
                    end else begin
                        if (chime_req_57) begin
                            w_pend_nxt   = 1'b1;
                            w_pend_n_nxt = w_chime_n;
                        end
                        if (tick_2hz_57) begin
                            w_tick_nxt = w_tick_inc;
                            if (w_tick_inc == ALARM_LIMIT) begin
                                w_state_nxt  = IDLE;
                                w_buzzer_nxt = 1'b0;
                                w_led_nxt    = 1'b0;
                            end else begin
                                w_buzzer_nxt = ~r_buzzer;
                            end
                        end
                    end
                end
                CHIME: begin
                    if (stop_57) begin
                        w_state_nxt  = IDLE;
                        w_buzzer_nxt = 1'b0;
                        w_led_nxt    = 1'b0;
                        w_pend_nxt   = 1'b0;
                    end else if (tick_2hz_57) begin
                        if (r_phase_on) begin
                            w_phase_on_nxt = 1'b0;
                            w_buzzer_nxt   = 1'b0;
                            w_led_nxt      = 1'b0;
                            w_beep_nxt     = r_beep_cnt - 4'd1;
                        end else if (r_beep_cnt == 4'd0) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_phase_on_nxt = 1'b1;
                            w_buzzer_nxt   = 1'b1;
                            w_led_nxt      = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_buzzer_nxt = 1'b0;
                    w_led_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m_57) begin
        if (!rst_n_57) begin
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_buzzer      <= 1'b0;
            r_led         <= 1'b0;
            r_sound_model <= 1'b0;
            r_chime_pend  <= 1'b0;
            r_pend_n      <= 4'd0;
            r_beep_cnt    <= 4'd0;
            r_phase_on    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_tick_cnt    <= w_tick_nxt;
            r_buzzer      <= w_buzzer_nxt;
            r_led         <= w_led_nxt;
            r_sound_model <= w_sound_model_nxt;
            r_chime_pend  <= w_pend_nxt;
            r_pend_n      <= w_pend_n_nxt;
            r_beep_cnt    <= w_beep_nxt;
            r_phase_on    <= w_phase_on_nxt;
        end
    end

    assign buzzer_57      = r_buzzer;
    assign led_57         = r_led;
    assign busy_57        = (r_state != IDLE);
    assign sound_model_57 = r_sound_model;

endmodule

// File: tb/tb_bell_sched_57.sv
// Directed bench for bell_sched_57 with a short alarm (4 ticks); outputs packed as {buzzer, led, busy, sound_model}.
module tb_bell_sched_57;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       tick = 1'b0;
    logic       alarmReq = 1'b0;
    logic       chimeReq = 1'b0;
    logic [6:0] hourBcd = 7'h00;
    logic       stopKey = 1'b0;
    logic       buzzer;
    logic       led;
    logic       busy;
    logic       soundModel;

    int checks = 0;
    int errors = 0;

    bell_sched_57 #(.ALARM_TICKS(4)) dut (
        .clk_50m_57     (clk),
        .rst_n_57       (rstN),
        .tick_2hz_57    (tick),
        .alarm_req_57   (alarmReq),
        .chime_req_57   (chimeReq),
        .hour_bcd_57    (hourBcd),
        .stop_57        (stopKey),
        .buzzer_57      (buzzer),
        .led_57         (led),
        .busy_57        (busy),
        .sound_model_57 (soundModel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs between falling edges; returns at the falling edge after the capture edge.
    task automatic applyStimulus(input logic a, input logic c, input logic t, input logic s, input logic [6:0] hr);
        @(negedge clk);
        alarmReq = a;
        chimeReq = c;
        tick     = t;
        stopKey  = s;
        hourBcd  = hr;
        @(negedge clk);
        alarmReq = 1'b0;
        chimeReq = 1'b0;
        tick     = 1'b0;
        stopKey  = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, hourBcd);
    endtask

    function automatic logic [3:0] outs();
        return {buzzer, led, busy, soundModel};
    endfunction

    // Remaining ticks of an N-beep chime already in its first ON phase.
    task automatic runChime(input string tag, input int n);
        logic [3:0] exp;
        for (int i = 1; i <= 2 * n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, hourBcd);
            if (i == 2 * n) exp = 4'b0001;
            else if (i % 2 == 1) exp = 4'b0011;
            else exp = 4'b1111;
            checkOutput($sformatf("%s tick%0d", tag, i), outs(), exp);
        end
    endtask

    // Four-tick alarm already entered: buzzer 0,1,0 then idle on the 4th tick.
    task automatic runAlarm(input string tag);
        logic [3:0] exp;
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, hourBcd);
            if (i == 4) exp = 4'b0000;
            else if (i % 2 == 1) exp = 4'b0110;
            else exp = 4'b1110;
            checkOutput($sformatf("%s tick%0d", tag, i), outs(), exp);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        checkOutput("reset", outs(), 4'b0000);

        // 15:00 -> three beeps, busy drops on the sixth tick
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h15);
        checkOutput("chime15 entry", outs(), 4'b1111);
        idleCycles(2);
        checkOutput("chime15 hold", outs(), 4'b1111);
        runChime("chime15", 3);
        idleCycles(2);
        checkOutput("chime15 idle", outs(), 4'b0001);

        // Alarm with a coincident tick that must be ignored
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 7'h00);
        checkOutput("alarm entry", outs(), 4'b1110);
        runAlarm("alarm");

        // Alarm restart after three ticks
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h00);
        checkOutput("restart pre", outs(), 4'b0110);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
        checkOutput("restart entry", outs(), 4'b1110);
        runAlarm("restart");

        // Alarm and midnight chime together: alarm first, then 12 beeps
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'h00);
        checkOutput("combo entry", outs(), 4'b1110);
        runAlarm("combo alarm");
        idleCycles(1);
        checkOutput("combo chime entry", outs(), 4'b1111);
        runChime("combo chime", 12);

        // Alarm preempts a 5-beep chime during its 2nd beep
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h05);
        checkOutput("preempt entry", outs(), 4'b1111);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h05);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h05);
        checkOutput("preempt beep2", outs(), 4'b1111);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'h05);
        checkOutput("preempt alarm", outs(), 4'b1110);
        runAlarm("preempt");
        idleCycles(3);
        checkOutput("preempt no chime", outs(), 4'b0000);

        // Stop during alarm clears the pending 9 o'clock chime
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'h09);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h09);
        checkOutput("stop pre", outs(), 4'b0110);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 7'h09);
        checkOutput("stop alarm", outs(), 4'b0000);
        idleCycles(3);
        checkOutput("stop no chime", outs(), 4'b0000);

        // Stop beats a coincident tick inside a noon chime
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h12);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 7'h12);
        checkOutput("stop chime", outs(), 4'b0001);

        // Reset mid-chime, then a one-beep chime (01:00)
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h23);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h23);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7'h23);
        checkOutput("reset pre", outs(), 4'b1111);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("reset mid", outs(), 4'b0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 7'h01);
        checkOutput("post reset entry", outs(), 4'b1111);
        runChime("post reset", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
